am_similarity_argmax: RTL and testbench

AM_SIMILARITY_ARGMAX -- requirements
Module: am_similarity_argmax

---
 rtl/am_similarity_argmax.sv | 149 ++++++++++++++
 tb/tb_am_similarity_argmax.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_similarity_argmax.sv
// Associative-memory search: popcounts AND-array chunks, sums them per class and
// tracks the best-matching class (argmax, lowest index wins ties) over one query.
module am_similarity_argmax #(
  parameter int DIMS_PER_CC   = 500,
  parameter int CHUNKS_PER_HV = 10,
  parameter int NUM_CLASSES   = 26,
  localparam int PC_W  = $clog2(DIMS_PER_CC + 1),
  localparam int SIM_W = $clog2(DIMS_PER_CC * CHUNKS_PER_HV + 1),
  localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int CC_W  = (CHUNKS_PER_HV > 1) ? $clog2(CHUNKS_PER_HV) : 1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [DIMS_PER_CC-1:0] and_array_out,
  output logic                   in_ready,
  output logic                   busy,
  output logic                   class_sim_valid,
  output logic [SIM_W-1:0]       class_sim,
  output logic [CLS_W-1:0]       class_idx,
  output logic                   done,
  output logic [CLS_W-1:0]       best_class,
  output logic [SIM_W-1:0]       best_sim
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

  state_t           state_q;
  logic [CC_W-1:0]  chunk_cnt_q;
  logic [CLS_W-1:0] cls_cnt_q;

  logic             pc_vld_q;
  logic [PC_W-1:0]  pc_q;
  logic             pc_first_q;
  logic             pc_last_q;
  logic [CLS_W-1:0] pc_cls_q;

  logic [SIM_W-1:0] acc_q;
  logic             class_sim_valid_q;
  logic [SIM_W-1:0] class_sim_q;
  logic [CLS_W-1:0] class_idx_q;
  logic [CLS_W-1:0] best_class_q;
  logic [SIM_W-1:0] best_sim_q;

  logic             accept;
  logic             chunk_last;
  logic             cls_last;
  logic [PC_W-1:0]  pc_d;
  logic [SIM_W-1:0] sum_d;

  assign in_ready   = (state_q == S_ACCUM);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign accept     = in_valid && in_ready;
  assign chunk_last = (chunk_cnt_q == CC_W'(CHUNKS_PER_HV - 1));
  assign cls_last   = (cls_cnt_q == CLS_W'(NUM_CLASSES - 1));

  always_comb begin
    pc_d = '0;
    for (int i = 0; i < DIMS_PER_CC; i++) begin
      pc_d = pc_d + PC_W'(and_array_out[i]);
    end
  end

  // First chunk of a class restarts the sum, so no separate clear cycle is needed.
  assign sum_d = pc_first_q ? SIM_W'(pc_q) : (acc_q + SIM_W'(pc_q));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q           <= S_IDLE;
      chunk_cnt_q       <= '0;
      cls_cnt_q         <= '0;
      pc_vld_q          <= 1'b0;
      pc_q              <= '0;
      pc_first_q        <= 1'b0;
      pc_last_q         <= 1'b0;
      pc_cls_q          <= '0;
      acc_q             <= '0;
      class_sim_valid_q <= 1'b0;
      class_sim_q       <= '0;
      class_idx_q       <= '0;
      best_class_q      <= '0;
      best_sim_q        <= '0;
    end else begin
      pc_vld_q <= accept;
      if (accept) begin
        pc_q       <= pc_d;
        pc_first_q <= (chunk_cnt_q == '0);
        pc_last_q  <= chunk_last;
        pc_cls_q   <= cls_cnt_q;
      end

      class_sim_valid_q <= pc_vld_q && pc_last_q;
      if (pc_vld_q) begin
        acc_q <= sum_d;
        if (pc_last_q) begin
          class_sim_q <= sum_d;
          class_idx_q <= pc_cls_q;
        end
      end

      // Strict compare keeps the lower index on ties.
      if (class_sim_valid_q && ((class_idx_q == '0) || (class_sim_q > best_sim_q))) begin
        best_sim_q   <= class_sim_q;
        best_class_q <= class_idx_q;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_ACCUM;
            chunk_cnt_q  <= '0;
            cls_cnt_q    <= '0;
            best_sim_q   <= '0;
            best_class_q <= '0;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            if (chunk_last) begin
              chunk_cnt_q <= '0;
              if (cls_last) begin
                state_q <= S_DRAIN;
              end else begin
                cls_cnt_q <= cls_cnt_q + CLS_W'(1);
              end
            end else begin
              chunk_cnt_q <= chunk_cnt_q + CC_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (class_sim_valid_q && (class_idx_q == CLS_W'(NUM_CLASSES - 1))) begin
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign class_sim_valid = class_sim_valid_q;
  assign class_sim       = class_sim_q;
  assign class_idx       = class_idx_q;
  assign best_class      = best_class_q;
  assign best_sim        = best_sim_q;

endmodule

// File: tb/tb_am_similarity_argmax.sv
// Scoreboard bench: a driver pushes expected class sums and argmax results derived
// from $countones over the issued chunks; a negedge monitor pops and compares them.
module tb_am_similarity_argmax;

  localparam int D     = 500;
  localparam int C     = 10;
  localparam int N     = 3;
  localparam int SIM_W = 13;
  localparam int CLS_W = 2;

  logic             clk = 1'b0;
  logic             nrst;
  logic             start;
  logic             in_valid;
  logic [D-1:0]     and_array_out;
  logic             in_ready;
  logic             busy;
  logic             class_sim_valid;
  logic [SIM_W-1:0] class_sim;
  logic [CLS_W-1:0] class_idx;
  logic             done;
  logic [CLS_W-1:0] best_class;
  logic [SIM_W-1:0] best_sim;

  logic       s_start;
  logic       s_in_valid;
  logic [7:0] s_data;
  logic       s_in_ready;
  logic       s_busy;
  logic       s_csv;
  logic [3:0] s_cs;
  logic [0:0] s_ci;
  logic       s_done;
  logic [0:0] s_bc;
  logic [3:0] s_bs;

  am_similarity_argmax #(.DIMS_PER_CC(D), .CHUNKS_PER_HV(C), .NUM_CLASSES(N)) u_dut (
    .clk(clk), .nrst(nrst), .start(start), .in_valid(in_valid),
    .and_array_out(and_array_out), .in_ready(in_ready), .busy(busy),
    .class_sim_valid(class_sim_valid), .class_sim(class_sim), .class_idx(class_idx),
    .done(done), .best_class(best_class), .best_sim(best_sim)
  );

  am_similarity_argmax #(.DIMS_PER_CC(8), .CHUNKS_PER_HV(1), .NUM_CLASSES(1)) u_small (
    .clk(clk), .nrst(nrst), .start(s_start), .in_valid(s_in_valid),
    .and_array_out(s_data), .in_ready(s_in_ready), .busy(s_busy),
    .class_sim_valid(s_csv), .class_sim(s_cs), .class_idx(s_ci),
    .done(s_done), .best_class(s_bc), .best_sim(s_bs)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     idx;
    int     sim;
    longint cyc;
  } exp_t;

  exp_t         sim_q[$];
  exp_t         done_q[$];
  int           checks   = 0;
  int           failures = 0;
  longint       cyc      = 0;
  int           last_exp_sim = 0;
  logic [D-1:0] chunks[N*C];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every presented result against the scoreboard.
  always @(negedge clk) begin
    if (nrst) begin
      if (class_sim_valid) begin
        if (sim_q.size() == 0) begin
          chk("unexpected_class_sim_valid", 1, 0);
        end else begin
          exp_t e;
          e = sim_q.pop_front();
          chk("class_sim", longint'(class_sim), e.sim);
          chk("class_idx", longint'(class_idx), e.idx);
          chk("class_sim_cycle", cyc, e.cyc);
          last_exp_sim = e.sim;
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = done_q.pop_front();
          chk("best_class", longint'(best_class), e.idx);
          chk("best_sim", longint'(best_sim), e.sim);
          chk("done_cycle", cyc, e.cyc);
          chk("class_sim_hold", longint'(class_sim), last_exp_sim);
          chk("class_idx_hold", longint'(class_idx), N - 1);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [D-1:0] ones_n(input int n);
    logic [D-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [D-1:0] rand_chunk();
    logic [D-1:0] v;
    for (int i = 0; i < D; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_chunk(input logic [D-1:0] data, output longint c);
    logic rdy;
    int   n;
    in_valid      = 1'b1;
    and_array_out = data;
    n = 0;
    c = -1;
    do begin
      @(negedge clk);
      rdy = in_ready;
      c   = cyc;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, longint'({in_ready, busy, class_sim_valid, done,
                        class_sim, class_idx, best_class, best_sim}), 0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && (sim_q.size() != 0 || done_q.size() != 0); i++) @(posedge clk);
    #1;
    chk("scoreboard_drained", sim_q.size() + done_q.size(), 0);
  endtask

  // Runs one query over chunks[]. abort_after >= 0 pulses reset after that many accepted chunks.
  task automatic run_query(input bit gaps, input bit start_mid, input int abort_after);
    int     sims[N];
    int     accepted;
    int     best_i;
    longint c;
    exp_t   e;
    accepted = 0;
    do_start();
    for (int k = 0; k < N; k++) begin
      sims[k] = 0;
      for (int j = 0; j < C; j++) begin
        if (accepted == abort_after) begin
          in_valid = 1'b0;
          nrst     = 1'b0;
          @(posedge clk); #1;
          @(negedge clk);
          chk_reset_outputs("outputs_in_reset");
          @(posedge clk); #1;
          nrst = 1'b1;
          return;
        end
        if (gaps) begin
          for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) begin
            in_valid      = 1'b0;
            and_array_out = rand_chunk();
            @(posedge clk); #1;
          end
        end
        if (start_mid && k == 1 && j == 3) start = 1'b1;
        send_chunk(chunks[k*C+j], c);
        start = 1'b0;
        accepted++;
        sims[k] += $countones(chunks[k*C+j]);
        if (j == C - 1) begin
          e.idx = k; e.sim = sims[k]; e.cyc = c + 2;
          sim_q.push_back(e);
        end
      end
    end
    in_valid = 1'b0;
    if (start_mid) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    best_i = 0;
    for (int k = 1; k < N; k++) if (sims[k] > sims[best_i]) best_i = k;
    e.idx = best_i; e.sim = sims[best_i]; e.cyc = c + 3;
    done_q.push_back(e);
    wait_drain();
  endtask

  initial begin
    logic [7:0] ff;
    nrst = 1'b0; start = 1'b0; in_valid = 1'b0; and_array_out = '0;
    s_start = 1'b0; s_in_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_outputs("reset_outputs");
    @(posedge clk); #1;
    nrst = 1'b1;

    // Class 0 all ones, class 1 all zeros, class 2 a single bit per chunk.
    for (int j = 0; j < C; j++) begin
      chunks[j]       = ones_n(D);
      chunks[C+j]     = '0;
      chunks[2*C+j]   = '0;
      chunks[2*C+j][j*7] = 1'b1;
    end
    run_query(1'b0, 1'b0, -1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("best_class_held_idle", longint'(best_class), 0);
    chk("best_sim_held_idle", longint'(best_sim), 5000);

    // Tie between classes 1 and 2; chunks offered while idle must be ignored.
    for (int j = 0; j < C; j++) begin
      chunks[j]     = ones_n(10);
      chunks[C+j]   = ones_n(j == C - 1 ? 127 : 123);
      chunks[2*C+j] = ones_n(j == 0 ? 127 : 123);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; and_array_out = ones_n(D);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    run_query(1'b0, 1'b0, -1);

    // Random chunks: gap-free, with gaps, and with stray start pulses.
    for (int i = 0; i < N * C; i++) chunks[i] = rand_chunk();
    run_query(1'b0, 1'b0, -1);
    run_query(1'b1, 1'b0, -1);
    run_query(1'b1, 1'b1, -1);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N * C; i++) chunks[i] = ($urandom_range(0, 3) == 0) ? ones_n(D) : rand_chunk();
      run_query(1'b1, 1'b0, -1);
    end

    // Reset after 7 chunks of class 1, then a fresh all-ones query.
    for (int i = 0; i < N * C; i++) chunks[i] = ones_n(D);
    run_query(1'b0, 1'b0, C + 7);
    wait_drain();
    run_query(1'b0, 1'b0, -1);

    // Minimal configuration: one 8-bit chunk, one class.
    ff = 8'hFF;
    @(posedge clk); #1;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0; s_in_valid = 1'b1; s_data = ff;
    @(negedge clk);
    chk("small_in_ready", longint'(s_in_ready), 1);
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    @(negedge clk);
    chk("small_valid_c1", longint'(s_csv), 0);
    @(negedge clk);
    chk("small_valid_c2", longint'(s_csv), 1);
    chk("small_class_sim", longint'(s_cs), 8);
    chk("small_class_idx", longint'(s_ci), 0);
    @(negedge clk);
    chk("small_done_c3", longint'(s_done), 1);
    chk("small_best_class", longint'(s_bc), 0);
    chk("small_best_sim", longint'(s_bs), 8);
    @(negedge clk);
    chk("small_busy_after", longint'(s_busy), 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
